// File: rtl/key_event.sv
// Debounced-key event generator: short press, long press and hold-to-repeat pulses.
// Optional double-click detection is compiled in with `define KEY_DCLICK_EN.
module key_event #(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int DCLICK_MS = 300,
  parameter int CNT_W     = 11
) (
  input  logic CP_1KHz,
  input  logic nCR,
  input  logic btn_in,
  output logic short_press,
  output logic long_press,
  output logic repeat_tick,
  output logic held,
  output logic dbl_click
);

`ifdef KEY_DCLICK_EN
  typedef enum logic [2:0] {LOCK, IDLE, PRESS, REPEAT, WAIT2, PRESS2} state_e;
`else
  typedef enum logic [2:0] {LOCK, IDLE, PRESS, REPEAT} state_e;
`endif

  localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_MS);
  localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_MS);
`ifdef KEY_DCLICK_EN
  localparam logic [CNT_W-1:0] DCLICK_C = CNT_W'(DCLICK_MS);
`endif

  localparam bit PARAMS_OK = (LONG_MS >= 2)   && (LONG_MS < 2**CNT_W) &&
                             (REPEAT_MS >= 1) && (REPEAT_MS < 2**CNT_W) &&
                             (DCLICK_MS >= 1) && (DCLICK_MS < 2**CNT_W);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d = cnt_q + CNT_W'(1);

  // Outputs are registered; pulses default low every cycle so each lasts one clock.
  always_ff @(posedge CP_1KHz or negedge nCR) begin
    if (!nCR) begin
      state_q     <= LOCK;
      cnt_q       <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      repeat_tick <= 1'b0;
      held        <= 1'b0;
      dbl_click   <= 1'b0;
    end else begin
      short_press <= 1'b0;
      long_press  <= 1'b0;
      repeat_tick <= 1'b0;
      dbl_click   <= 1'b0;
      case (state_q)
        // A key held through reset must be released before it can count.
        LOCK: begin
          if (!btn_in) state_q <= IDLE;
        end
        IDLE: begin
          if (btn_in) begin
            state_q <= PRESS;
            cnt_q   <= CNT_W'(1);
            held    <= 1'b1;
          end
        end
        PRESS: begin
          if (btn_in) begin
            if (cnt_d == LONG_C) begin
              long_press <= 1'b1;
              cnt_q      <= '0;
              state_q    <= REPEAT;
            end else begin
              cnt_q <= cnt_d;
            end
          end else begin
            held  <= 1'b0;
            cnt_q <= '0;
`ifdef KEY_DCLICK_EN
            state_q <= WAIT2;
`else
            short_press <= 1'b1;
            state_q     <= IDLE;
`endif
          end
        end
        REPEAT: begin
          if (btn_in) begin
            if (cnt_d == REPEAT_C) begin
              repeat_tick <= 1'b1;
              cnt_q       <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end else begin
            held    <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
`ifdef KEY_DCLICK_EN
        WAIT2: begin
          if (btn_in) begin
            state_q <= PRESS2;
            cnt_q   <= CNT_W'(1);
            held    <= 1'b1;
          end else if (cnt_d == DCLICK_C) begin
            short_press <= 1'b1;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        // Long hold on the second press settles the first press as a short one.
        PRESS2: begin
          if (btn_in) begin
            if (cnt_d == LONG_C) begin
              short_press <= 1'b1;
              long_press  <= 1'b1;
              cnt_q       <= '0;
              state_q     <= REPEAT;
            end else begin
              cnt_q <= cnt_d;
            end
          end else begin
            dbl_click <= 1'b1;
            held      <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end
        end
`endif
        default: begin
          state_q <= LOCK;
          cnt_q   <= '0;
          held    <= 1'b0;
        end
      endcase
    end
  end

  param_chk: assert property (@(posedge CP_1KHz) PARAMS_OK)
    else $error("key_event: parameter out of range");

`ifdef KEY_DCLICK_EN
  excl_chk: assert property (@(posedge CP_1KHz) disable iff (!nCR)
    $onehot0({short_press & ~long_press, long_press, repeat_tick, dbl_click}));
`else
  excl_chk: assert property (@(posedge CP_1KHz) disable iff (!nCR)
    $onehot0({short_press, long_press, repeat_tick, dbl_click}));
`endif

endmodule
